// File: rtl/fnn_pkg.sv
// Shared types and helpers for the fully connected network blocks.
package fnn_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        STREAM  = 1'b1
    } ser_state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Gathers one layer's parallel neuron outputs, then replays them as a
// gap-free one-word-per-cycle stream for the next layer's input broadcast.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int numNeurons = 10,
    parameter int dataWidth  = 16,
    localparam int IW        = idx_w(numNeurons)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] neuron_out,
    input  logic [numNeurons-1:0]           neuron_valid,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    output logic [IW-1:0]                   out_idx,
    output logic                            frame_done,
    output logic                            busy,
    output logic                            overflow
);

    localparam logic [IW-1:0] LAST = IW'(numNeurons - 1);

    ser_state_t             state, state_d;
    logic [numNeurons-1:0]  cap;
    logic [IW-1:0]          cnt;
    logic [dataWidth-1:0]   word_buf [numNeurons];
    logic                   cap_all;
    logic                   last;

    // State register; reset mid-frame abandons the partial stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COLLECT;
        else      state <= state_d;
    end

    // Next state: leave COLLECT once every neuron (including this cycle's) has reported.
    always_comb begin
        cap_all = &(cap | neuron_valid);
        last    = (cnt == LAST);
        state_d = state;
        case (state)
            COLLECT: if (cap_all) state_d = STREAM;
            STREAM:  if (last)    state_d = COLLECT;
        endcase
    end

    // Capture buffer, read counter and registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap        <= '0;
            cnt        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < numNeurons; i++) word_buf[i] <= '0;
        end else begin
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            if (state == COLLECT) begin
                // Latest valid per neuron wins; the buffer is written in parallel.
                for (int i = 0; i < numNeurons; i++)
                    if (neuron_valid[i]) word_buf[i] <= neuron_out[i*dataWidth +: dataWidth];
                if (cap_all) begin
                    cap <= '0;
                    cnt <= '0;
                end else begin
                    cap <= cap | neuron_valid;
                end
            end else begin
                // Outputs arriving mid-stream cannot be stored without corrupting the frame.
                if (|neuron_valid) overflow <= 1'b1;
                out_valid  <= 1'b1;
                busy       <= 1'b1;
                out_data   <= word_buf[cnt];
                out_idx    <= cnt;
                frame_done <= last;
                cnt        <= last ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with four 16-bit neurons.
module tb_layer_out_serializer;

    logic        clk;
    logic        rst;
    logic [63:0] neuron_out;
    logic [3:0]  neuron_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic [1:0]  out_idx;
    logic        frame_done;
    logic        busy;
    logic        overflow;

    int vecs = 0;
    int errs = 0;

    layer_out_serializer #(.numNeurons(4), .dataWidth(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .neuron_out   (neuron_out),
        .neuron_valid (neuron_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_idx      (out_idx),
        .frame_done   (frame_done),
        .busy         (busy),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [63:0] w);
        neuron_valid = v;
        neuron_out   = w;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Expects four consecutive words, one per edge, word k in w[k*16 +: 16].
    task automatic expect_frame(input string tag, input logic [63:0] w);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("%s w%0d valid", tag, k), 32'(out_valid), 32'd1);
            chk($sformatf("%s w%0d busy", tag, k), 32'(busy), 32'd1);
            chk($sformatf("%s w%0d data", tag, k), 32'(out_data), 32'(w[k*16 +: 16]));
            chk($sformatf("%s w%0d idx", tag, k), 32'(out_idx), 32'(k));
            chk($sformatf("%s w%0d done", tag, k), 32'(frame_done), 32'(k == 3));
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(4'b0000, 64'h0);
        #3;
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_idx", 32'(out_idx), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk_idle("reset");
        tick();
        rst = 1'b1;
        tick();
        chk_idle("post reset");

        // Simultaneous capture of all four neurons.
        drive(4'b1111, 64'h0044_0033_0022_0011);
        tick();
        drive(4'b0000, 64'h0);
        chk_idle("simul capture edge");
        expect_frame("simul", 64'h0044_0033_0022_0011);
        tick();
        chk_idle("simul after");
        chk("simul hold data", 32'(out_data), 32'h0044);
        chk("simul done low", 32'(frame_done), 32'd0);

        // Staggered capture with a repeat on neuron 0.
        drive(4'b0001, 64'h0000_0000_0000_AAAA); tick();
        drive(4'b0100, 64'h0000_0C0C_0000_0000); tick();
        drive(4'b0010, 64'h0000_0000_0B0B_0000); tick();
        drive(4'b0001, 64'h0000_0000_0000_BEEF); tick();
        chk_idle("stagger partial");
        drive(4'b1000, 64'h0D0D_0000_0000_0000); tick();
        drive(4'b0000, 64'h0);
        chk_idle("stagger capture edge");
        expect_frame("stagger", 64'h0D0D_0C0C_0B0B_BEEF);
        tick();
        chk_idle("stagger after");

        // Overflow: a valid arriving while word 0 is on the output.
        drive(4'b1111, 64'h1003_1002_1001_1000);
        tick();
        drive(4'b0000, 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("ovf w%0d data", k), 32'(out_data), 32'(16'h1000 + k));
            chk($sformatf("ovf w%0d valid", k), 32'(out_valid), 32'd1);
            if (k == 0) drive(4'b0001, 64'h0000_0000_0000_7FFF);
            else        drive(4'b0000, 64'h0);
        end
        chk("ovf flag set", 32'(overflow), 32'd1);
        tick();
        chk_idle("ovf after");
        drive(4'b0111, 64'h0000_4002_4001_4000); tick();
        drive(4'b0000, 64'h0); tick(); tick();
        chk_idle("ovf needs all four");
        drive(4'b1000, 64'h4003_0000_0000_0000); tick();
        drive(4'b0000, 64'h0);
        chk_idle("ovf refill edge");
        expect_frame("ovf next", 64'h4003_4002_4001_4000);
        chk("ovf sticky", 32'(overflow), 32'd1);
        tick();

        // Reset asserted while word 1 is on the output.
        drive(4'b1111, 64'h2003_2002_2001_2000);
        tick();
        drive(4'b0000, 64'h0);
        tick();
        chk("rst w0 data", 32'(out_data), 32'h2000);
        tick();
        chk("rst w1 idx", 32'(out_idx), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_idle("rst async");
        chk("rst overflow cleared", 32'(overflow), 32'd0);
        chk("rst out_data cleared", 32'(out_data), 32'd0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rst no resume %0d", k), 32'(out_valid), 32'd0);
        end
        drive(4'b1111, 64'h3003_3002_3001_3000);
        tick();
        drive(4'b0000, 64'h0);
        expect_frame("post rst", 64'h3003_3002_3001_3000);

        // Back-to-back: next frame sampled at the edge ending the frame_done cycle.
        drive(4'b1111, 64'h0000_0001_FFFF_8000);
        tick();
        drive(4'b0000, 64'h0);
        chk_idle("b2b gap");
        expect_frame("b2b", 64'h0000_0001_FFFF_8000);
        tick();
        chk_idle("b2b after");
        chk("b2b overflow clear", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
